// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
// Holds default widths/counts, range-check limits for the counter widths,
// and the encoding of a debounced button level.
package debounce_pkg;

  // Default configuration of debounce_multi
  localparam int DEF_N_CH       = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_STABLE_CNT = 200;
  localparam int DEF_LONG_W     = 12;
  localparam int DEF_LONG_CNT   = 2048;

  // Legal ranges for the counter widths and the terminal counts
  localparam int CNT_W_MIN      = 2;
  localparam int CNT_W_MAX      = 31;
  localparam int LONG_W_MIN     = 1;
  localparam int LONG_W_MAX     = 31;
  localparam int STABLE_CNT_MIN = 2;
  localparam int LONG_CNT_MIN   = 1;

  // Debounced level encoding (1 = pressed)
  typedef enum logic {
    LVL_RELEASED = 1'b0,
    LVL_PRESSED  = 1'b1
  } level_e;

  // True when 'value' lies in [lo, 2**width-1]
  function automatic bit count_fits(input int width, input int lo, input int value);
    return (value >= lo) && (value <= ((32'sd1 <<< width) - 32'sd1));
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bundle between the board-side stimulus and the debouncer.
//   debounce_en    global filter enable
//   button         raw asynchronous buttons (1 = pressed)
//   btn_level      debounced level per channel
//   press_pulse    one-cycle pulse on accepted 0->1
//   release_pulse  one-cycle pulse on accepted 1->0
//   long_pulse     one-cycle pulse after a long hold (0 unless LONG_PRESS_EN)
//   prell_flag     some channel is currently filtering a bounce
// master: the side that drives the buttons; slave: the debouncer.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic            debounce_en;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            prell_flag;

  modport master (
    output debounce_en, button,
    input  btn_level, press_pulse, release_pulse, long_pulse, prell_flag
  );

  modport slave (
    input  debounce_en, button,
    output btn_level, press_pulse, release_pulse, long_pulse, prell_flag
  );
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level and registered press/release pulses. With the LONG_PRESS_EN macro
// defined, a hold counter also produces a single long_pulse per press.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   en             filter enable (0: counter cleared, level frozen)
//   button         raw asynchronous input
//   level          debounced level
//   press_pulse    one-cycle pulse on accepted 0->1
//   release_pulse  one-cycle pulse on accepted 1->0
//   long_pulse     one-cycle pulse after LONG_CNT enabled pressed cycles
//   busy           stability counter is non-zero (bounce being filtered)
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_W     = DEF_LONG_W,
  parameter int LONG_CNT   = DEF_LONG_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic busy
);

  // Accept on the sample that would take the counter to STABLE_CNT, so it never wraps
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CNT - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic             release_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;

  // Next stability count and acceptance decision
  always_comb begin
    cnt_nxt_s = cnt_r;
    accept_s  = 1'b0;
    if (!en) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (sync2_r == level_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_TERM) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      accept_s  = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Synchroniser, counter, level and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      level_r   <= LVL_RELEASED;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r   <= button;
      sync2_r   <= sync1_r;
      cnt_r     <= cnt_nxt_s;
      press_r   <= accept_s && (sync2_r == LVL_PRESSED);
      release_r <= accept_s && (sync2_r == LVL_RELEASED);
      if (accept_s) begin
        level_r <= sync2_r;
      end else begin
        level_r <= level_r;
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HOLD_TERM = LONG_W'(LONG_CNT);
  localparam logic [LONG_W-1:0] HOLD_PRE  = LONG_W'(LONG_CNT - 1);

  logic [LONG_W-1:0] hold_r;
  logic              long_r;

  // Hold counter: counts enabled pressed cycles, saturates, cleared by release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= {LONG_W{1'b0}};
      long_r <= 1'b0;
    end else begin
      long_r <= 1'b0;
      if (accept_s && (sync2_r == LVL_RELEASED)) begin
        hold_r <= {LONG_W{1'b0}};
      end else if (en && (level_r == LVL_PRESSED) && (hold_r != HOLD_TERM)) begin
        hold_r <= hold_r + LONG_W'(1);
        long_r <= (hold_r == HOLD_PRE);
      end
    end
  end

  assign long_pulse = long_r;
`else
  assign long_pulse = 1'b0;
`endif

  assign level         = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign busy          = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/debounce_multi.sv
// N-channel pushbutton debouncer for the clk_1024 domain. Each channel is an
// independent debounce_ch; prell_flag reports any channel mid-bounce.
// Optional feature macro: LONG_PRESS_EN (long-press detection on long_pulse).
// Ports:
//   clk_1024  system clock (1024 Hz tick domain)
//   reset_n   asynchronous active-low reset
//   bus       debounce_multi_if.slave: debounce_en, button in;
//             btn_level, press_pulse, release_pulse, long_pulse, prell_flag out
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_W     = DEF_LONG_W,
  parameter int LONG_CNT   = DEF_LONG_CNT
) (
  input  logic            clk_1024,
  input  logic            reset_n,
  debounce_multi_if.slave bus
);

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] press_s;
  logic [N_CH-1:0] release_s;
  logic [N_CH-1:0] long_s;
  logic [N_CH-1:0] busy_s;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_ch #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .LONG_W     (LONG_W),
      .LONG_CNT   (LONG_CNT)
    ) u_ch (
      .clk           (clk_1024),
      .rst_n         (reset_n),
      .en            (bus.debounce_en),
      .button        (bus.button[c]),
      .level         (level_s[c]),
      .press_pulse   (press_s[c]),
      .release_pulse (release_s[c]),
      .long_pulse    (long_s[c]),
      .busy          (busy_s[c])
    );
  end

  assign bus.btn_level     = level_s;
  assign bus.press_pulse   = press_s;
  assign bus.release_pulse = release_s;
  assign bus.long_pulse    = long_s;
  // OR of register-derived flags: glitch-free in practice and 0 during reset
  assign bus.prell_flag    = |busy_s;

endmodule
